// File: rtl/router_pkg.sv
// router_pkg: shared flit type, framing states and default flit width for the router input buffer
package router_pkg;
  localparam int DEFAULT_FLIT_WIDTH = 32;
  typedef logic [DEFAULT_FLIT_WIDTH-1:0] flit_t;
  typedef enum logic [1:0] {IB_HEADER, IB_SIZE, IB_PAYLOAD} ibuf_state_t;
endpackage

// File: rtl/router_input_buffer_flit_fifo.sv
// flit_fifo: circular flit store with pointers, occupancy count, credit and head-valid
// Ports: clock, reset (async, active-high); push/wdata write side; pop read side;
//        credit = room for a flit, valid = non-empty, rdata = head flit (0 when empty)
module flit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             credit,
  output logic             valid,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  // credit follows the registered count only, so a pop while full frees room a cycle later
  assign credit  = !reset && (count != FULL);
  assign valid   = count != '0;
  assign do_push = push && credit;
  assign do_pop  = pop && valid;
  assign rdata   = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/router_input_buffer.sv
// router_input_buffer: credit-based input buffer with packet framing (header, size, payload)
// Ports: clock, reset (async, active-high); rx_in/data_in/credit_out upstream handshake;
//        tx_out/data_out/sop_out/eop_out/ack_in head-flit interface to the switch.
// Define ROUTER_IBUF_ERR_EN to add sticky err_out (overflow or underflow attempt).
module router_input_buffer
  import router_pkg::*;
#(
  parameter int FLIT_WIDTH   = DEFAULT_FLIT_WIDTH,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  credit_out,
  output logic                  tx_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  sop_out,
  output logic                  eop_out,
  input  logic                  ack_in
`ifdef ROUTER_IBUF_ERR_EN
  ,
  output logic                  err_out
`endif
);
  ibuf_state_t state, state_nxt;
  logic [FLIT_WIDTH-1:0] remaining, remaining_nxt;
  logic pop;
  flit_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(BUFFER_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_in),
    .wdata (data_in),
    .pop   (ack_in),
    .credit(credit_out),
    .valid (tx_out),
    .rdata (data_out)
  );
  assign pop = ack_in && tx_out;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IB_HEADER;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end
  // framing only advances when the switch actually takes the head flit
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    sop_out       = 1'b0;
    eop_out       = 1'b0;
    case (state)
      IB_HEADER: begin
        sop_out = tx_out;
        if (pop) state_nxt = IB_SIZE;
      end
      IB_SIZE: begin
        eop_out = tx_out && (data_out == '0);
        if (pop) begin
          remaining_nxt = data_out;
          state_nxt     = (data_out == '0) ? IB_HEADER : IB_PAYLOAD;
        end
      end
      IB_PAYLOAD: begin
        eop_out = tx_out && (remaining == FLIT_WIDTH'(1));
        if (pop) begin
          remaining_nxt = remaining - 1'b1;
          state_nxt     = (remaining == FLIT_WIDTH'(1)) ? IB_HEADER : IB_PAYLOAD;
        end
      end
      default: state_nxt = IB_HEADER;
    endcase
  end
`ifdef ROUTER_IBUF_ERR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_out <= 1'b0;
    else if ((rx_in && !credit_out) || (ack_in && !tx_out)) err_out <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_router_input_buffer.sv
// tb_router_input_buffer: scoreboard bench for router_input_buffer (DEPTH 4, 32-bit flits)
module tb_router_input_buffer;
  localparam int W = 32;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b0;
  logic ack_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic credit_out, tx_out, sop_out, eop_out;
  logic [W-1:0] data_out;
`ifdef ROUTER_IBUF_ERR_EN
  logic err_out;
`endif
  router_input_buffer #(.FLIT_WIDTH(W), .BUFFER_DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_in     (rx_in),
    .data_in   (data_in),
    .credit_out(credit_out),
    .tx_out    (tx_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .ack_in    (ack_in)
`ifdef ROUTER_IBUF_ERR_EN
    ,
    .err_out   (err_out)
`endif
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
  } ent_t;
  ent_t q[$];
  int cnt = 0;
  int pst = 0;
  logic [W-1:0] prem = '0;
  logic err_m = 1'b0;
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // framing is derived from the push stream, independent of the pop-side FSM
  function automatic ent_t frame(input logic [W-1:0] d);
    ent_t e;
    e.d = d;
    e.sop = 1'b0;
    e.eop = 1'b0;
    if (pst == 0) begin
      e.sop = 1'b1;
      pst = 1;
    end else if (pst == 1) begin
      e.eop = (d == '0);
      prem = d;
      pst = (d == '0) ? 0 : 2;
    end else begin
      e.eop = (prem == 1);
      prem = prem - 1;
      if (prem == '0) pst = 0;
    end
    return e;
  endfunction
  task automatic step(input logic rx, input logic [W-1:0] d, input logic ack, output logic acc);
    logic pop;
    @(negedge clock);
    check("credit", W'(credit_out), W'(cnt != D));
    check("tx", W'(tx_out), W'(cnt != 0));
    if (cnt != 0) begin
      check("data", data_out, q[0].d);
      check("sop", W'(sop_out), W'(q[0].sop));
      check("eop", W'(eop_out), W'(q[0].eop));
    end else begin
      check("data_empty", data_out, '0);
      check("sop_empty", W'(sop_out), '0);
      check("eop_empty", W'(eop_out), '0);
    end
`ifdef ROUTER_IBUF_ERR_EN
    check("err", W'(err_out), W'(err_m));
`endif
    rx_in = rx;
    data_in = d;
    ack_in = ack;
    acc = rx && (cnt != D);
    pop = ack && (cnt != 0);
    err_m = err_m | (rx && cnt == D) | (ack && cnt == 0);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(frame(d));
    cnt = cnt + int'(acc) - int'(pop);
  endtask
  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && cnt != 0; i++) step(1'b0, '0, 1'b1, a);
    if (cnt != 0) check("drain_timeout", W'(cnt), '0);
    step(1'b0, '0, 1'b0, a);
  endtask
  task automatic hit_reset();
    @(negedge clock);
    rx_in = 1'b0;
    ack_in = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_tx", W'(tx_out), '0);
    check("rst_data", data_out, '0);
    check("rst_credit", W'(credit_out), '0);
    check("rst_sop", W'(sop_out), '0);
`ifdef ROUTER_IBUF_ERR_EN
    check("rst_err", W'(err_out), '0);
`endif
    q.delete();
    cnt = 0;
    pst = 0;
    prem = '0;
    err_m = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_credit", W'(credit_out), 1);
  endtask
  initial begin
    logic a;
    logic [W-1:0] pkt[$];
    int idx;
    repeat (2) @(negedge clock);
    check("init_credit", W'(credit_out), '0);
    check("init_tx", W'(tx_out), '0);
    check("init_data", data_out, '0);
    check("init_eop", W'(eop_out), '0);
    reset = 1'b0;
    #1;
    check("init_credit_release", W'(credit_out), 1);
    step(1'b0, '0, 1'b0, a);
    pkt = '{32'h05, 32'h03, 32'h0A, 32'h0B, 32'h0C};
    foreach (pkt[i]) step(1'b1, pkt[i], 1'b1, a);
    drain();
    for (int i = 1; i <= 6; i++) step(1'b1, W'(i), 1'b0, a);
    drain();
    pkt = '{32'h07, 32'h00, 32'h08, 32'h00};
    foreach (pkt[i]) step(1'b1, pkt[i], 1'b0, a);
    drain();
    pkt.delete();
    pkt.push_back(32'h30);
    pkt.push_back(32'd18);
    for (int i = 0; i < 18; i++) pkt.push_back(32'h100 + W'(i));
    idx = 0;
    for (int t = 0; t < 200 && idx < 20; t++) begin
      step(1'b1, pkt[idx], t[0], a);
      if (a) idx++;
    end
    if (idx != 20) check("wrap_timeout", W'(idx), 20);
    drain();
    pkt = '{32'h09, 32'h05, 32'h11};
    foreach (pkt[i]) step(1'b1, pkt[i], 1'b0, a);
    step(1'b0, '0, 1'b0, a);
    hit_reset();
    pkt = '{32'h0A, 32'h01, 32'h22};
    foreach (pkt[i]) step(1'b1, pkt[i], 1'b1, a);
    drain();
    step(1'b0, '0, 1'b1, a);
    step(1'b0, '0, 1'b0, a);
    hit_reset();
    step(1'b0, '0, 1'b0, a);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
